// File: rtl/instr_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// instr_sequencer_pkg
// Shared definitions for the 9-bit-ISA control sequencer.
//   HALT_CODE   : instruction word that stops the program
//   seq_state_t : sequencer FSM states
// -----------------------------------------------------------------------------
package instr_sequencer_pkg;

    // A full-ones instruction word stops the program.
    localparam logic [8:0] HALT_CODE = 9'h1FF;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        MEM,
        HALT
    } seq_state_t;

endpackage

// File: rtl/instr_sequencer_watchdog.sv
// -----------------------------------------------------------------------------
// mem_watchdog
// Counts cycles spent waiting for a data-memory completion.
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   clear   : zero the counter (takes priority over enable)
//   enable  : count one cycle of waiting
//   expired : counter has reached TIMEOUT-1
// -----------------------------------------------------------------------------
module mem_watchdog #(
    parameter int TMO_W   = 4,
    parameter int TIMEOUT = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TMO_W-1:0] count;

    // The counter stops at its terminal value so it can never wrap back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + TMO_W'(1);
        end
    end

    assign expired = (count == TMO_W'(TIMEOUT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
// Multi-cycle control FSM for the 9-bit-ISA datapath: fetch, execute,
// optional data-memory access and halt. Every architectural side effect is
// issued as a single-cycle commit strobe.
//   Clk, Reset          : clock, asynchronous active-high reset
//   Start               : run the program from PC 0 (ignored while busy)
//   Instruction         : IR contents, valid from EXEC onward
//   branch_en .. reg_wr_en : decoder control outputs
//   FLAG_IN             : current branch flag
//   mem_ack             : data-memory completion pulse
//   pc_reset/ir_load/pc_inc/pc_branch : fetch-unit strobes
//   reg_commit/flag_commit/ovf_commit : register write strobes
//   mem_req/mem_we      : data-memory request and store qualifier
//   busy/Done/bus_err   : run status
//   cycle_count         : saturating count of busy cycles
// -----------------------------------------------------------------------------
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int CYC_W       = 16,
    parameter int TMO_W       = 4,
    parameter int MEM_TIMEOUT = 12
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [8:0]       Instruction,
    input  logic             branch_en,
    input  logic             flag_write,
    input  logic             overflow_write,
    input  logic             MEM_READ,
    input  logic             MEM_WRITE,
    input  logic             reg_wr_en,
    input  logic             FLAG_IN,
    input  logic             mem_ack,
    output logic             pc_reset,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_branch,
    output logic             reg_commit,
    output logic             flag_commit,
    output logic             ovf_commit,
    output logic             mem_req,
    output logic             mem_we,
    output logic             busy,
    output logic             Done,
    output logic             bus_err,
    output logic [CYC_W-1:0] cycle_count
);

    seq_state_t state;
    seq_state_t state_next;

    logic wd_clear;
    logic wd_enable;
    logic wd_expired;
    logic set_bus_err;
    logic take_branch;

    mem_watchdog #(
        .TMO_W   (TMO_W),
        .TIMEOUT (MEM_TIMEOUT)
    ) u_watchdog (
        .clk     (Clk),
        .rst     (Reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    assign take_branch = branch_en & FLAG_IN;
    assign busy        = (state == FETCH) || (state == EXEC) || (state == MEM);

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and commit strobes. Strobes depend only on the current state
    // and inputs, so an asynchronous reset silences them immediately.
    always_comb begin
        state_next  = state;
        pc_reset    = 1'b0;
        ir_load     = 1'b0;
        pc_inc      = 1'b0;
        pc_branch   = 1'b0;
        reg_commit  = 1'b0;
        flag_commit = 1'b0;
        ovf_commit  = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        wd_clear    = 1'b0;
        wd_enable   = 1'b0;
        set_bus_err = 1'b0;

        case (state)
            IDLE, HALT: begin
                if (Start) begin
                    pc_reset   = 1'b1;
                    state_next = FETCH;
                end
            end

            FETCH: begin
                ir_load    = 1'b1;
                state_next = EXEC;
            end

            EXEC: begin
                if (Instruction == HALT_CODE) begin
                    state_next = HALT;
                end else if (MEM_READ || MEM_WRITE) begin
                    wd_clear   = 1'b1;
                    state_next = MEM;
                end else begin
                    reg_commit  = reg_wr_en;
                    flag_commit = flag_write;
                    ovf_commit  = overflow_write;
                    pc_branch   = take_branch;
                    pc_inc      = !take_branch;
                    state_next  = FETCH;
                end
            end

            MEM: begin
                mem_req   = 1'b1;
                mem_we    = MEM_WRITE;
                wd_enable = 1'b1;
                // An ack arriving in the final allowed cycle still completes.
                if (mem_ack) begin
                    reg_commit = MEM_READ;
                    pc_inc     = 1'b1;
                    state_next = FETCH;
                end else if (wd_expired) begin
                    set_bus_err = 1'b1;
                    state_next  = HALT;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Run status and cycle accounting. Done follows entry into HALT; a Start
    // from IDLE or HALT (seen as pc_reset) clears everything for the new run.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Done        <= 1'b0;
            bus_err     <= 1'b0;
            cycle_count <= '0;
        end else if (pc_reset) begin
            Done        <= 1'b0;
            bus_err     <= 1'b0;
            cycle_count <= '0;
        end else begin
            Done <= (state_next == HALT);
            if (set_bus_err) begin
                bus_err <= 1'b1;
            end
            if (busy && (cycle_count != {CYC_W{1'b1}})) begin
                cycle_count <= cycle_count + CYC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
// Self-checking bench for instr_sequencer. Programs are described at the
// instruction level; the expected strobes for every cycle come from the
// sequencing rules applied per instruction kind.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instr_sequencer;
    import instr_sequencer_pkg::*;

    localparam int CYC_W       = 16;
    localparam int TMO_W       = 4;
    localparam int MEM_TIMEOUT = 12;

    localparam int K_ALU  = 0;
    localparam int K_LW   = 1;
    localparam int K_SW   = 2;
    localparam int K_HALT = 3;

    // One program instruction; ack_at is the MEM cycle index carrying mem_ack
    // (negative means the memory never answers).
    typedef struct {
        int         kind;
        logic [8:0] code;
        logic       br;
        logic       fw;
        logic       ow;
        logic       rw;
        logic       flag;
        int         ack_at;
    } instr_t;

    logic             Clk;
    logic             Reset;
    logic             Start;
    logic [8:0]       Instruction;
    logic             branch_en;
    logic             flag_write;
    logic             overflow_write;
    logic             MEM_READ;
    logic             MEM_WRITE;
    logic             reg_wr_en;
    logic             FLAG_IN;
    logic             mem_ack;
    logic             pc_reset;
    logic             ir_load;
    logic             pc_inc;
    logic             pc_branch;
    logic             reg_commit;
    logic             flag_commit;
    logic             ovf_commit;
    logic             mem_req;
    logic             mem_we;
    logic             busy;
    logic             Done;
    logic             bus_err;
    logic [CYC_W-1:0] cycle_count;

    int checks_done   = 0;
    int checks_failed = 0;

    logic model_done;
    logic model_bus_err;
    int   model_cycles;
    int   prog_id;

    instr_t program_q[$];

    instr_sequencer #(
        .CYC_W       (CYC_W),
        .TMO_W       (TMO_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Start          (Start),
        .Instruction    (Instruction),
        .branch_en      (branch_en),
        .flag_write     (flag_write),
        .overflow_write (overflow_write),
        .MEM_READ       (MEM_READ),
        .MEM_WRITE      (MEM_WRITE),
        .reg_wr_en      (reg_wr_en),
        .FLAG_IN        (FLAG_IN),
        .mem_ack        (mem_ack),
        .pc_reset       (pc_reset),
        .ir_load        (ir_load),
        .pc_inc         (pc_inc),
        .pc_branch      (pc_branch),
        .reg_commit     (reg_commit),
        .flag_commit    (flag_commit),
        .ovf_commit     (ovf_commit),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .busy           (busy),
        .Done           (Done),
        .bus_err        (bus_err),
        .cycle_count    (cycle_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks_done++;
        if (observed !== expected) begin
            checks_failed++;
            $display("[TB] FAIL %s (prog %0d): got 0x%0h, expected 0x%0h at %0t",
                     tag, prog_id, observed, expected, $time);
        end
    endtask

    function automatic logic [11:0] observedStrobes();
        return {pc_reset, ir_load, pc_inc, pc_branch, reg_commit, flag_commit,
                ovf_commit, mem_req, mem_we, busy, Done, bus_err};
    endfunction

    function automatic logic [11:0] packExp(input logic pcr, input logic irl,
                                            input logic pci, input logic pcb,
                                            input logic rc, input logic fc,
                                            input logic oc, input logic mr,
                                            input logic mw, input logic bz);
        return {pcr, irl, pci, pcb, rc, fc, oc, mr, mw, bz, model_done, model_bus_err};
    endfunction

    // Check one cycle at the falling edge, then advance past the rising edge.
    task automatic stepCheck(input string tag, input logic [11:0] exp_vec,
                             input logic busy_cycle);
        @(negedge Clk);
        checkOutput(tag, {20'b0, observedStrobes()}, {20'b0, exp_vec});
        @(posedge Clk);
        #1;
        if (busy_cycle && model_cycles < 65535) model_cycles++;
    endtask

    // Decoder outputs and IR are don't-care outside EXEC/MEM.
    task automatic randomizeJunk();
        Instruction    = 9'($urandom);
        branch_en      = 1'($urandom);
        flag_write     = 1'($urandom);
        overflow_write = 1'($urandom);
        MEM_READ       = 1'($urandom);
        MEM_WRITE      = 1'($urandom);
        reg_wr_en      = 1'($urandom);
        FLAG_IN        = 1'($urandom);
        mem_ack        = 1'($urandom);
    endtask

    function automatic instr_t mkInstr(input int kind, input logic br, input logic fw,
                                       input logic ow, input logic rw, input logic flag,
                                       input int ack_at);
        instr_t ins;
        ins.kind   = kind;
        ins.code   = (kind == K_HALT) ? HALT_CODE : 9'($urandom_range(0, 510));
        ins.br     = br;
        ins.fw     = fw;
        ins.ow     = ow;
        ins.rw     = rw;
        ins.flag   = flag;
        ins.ack_at = ack_at;
        return ins;
    endfunction

    // Start the program held in program_q and check every cycle until HALT.
    task automatic applyStimulus();
        logic timed_out;
        logic is_rd;
        logic is_wr;
        logic taken;
        instr_t ins;

        randomizeJunk();
        Start = 1'b1;
        stepCheck("start", packExp(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        model_done    = 1'b0;
        model_bus_err = 1'b0;
        model_cycles  = 0;
        timed_out     = 1'b0;

        foreach (program_q[i]) begin
            ins = program_q[i];

            randomizeJunk();
            Start = ($urandom_range(0, 3) == 0);
            stepCheck("fetch", packExp(0, 1, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1);

            is_rd          = (ins.kind == K_LW);
            is_wr          = (ins.kind == K_SW);
            Instruction    = ins.code;
            branch_en      = ins.br;
            flag_write     = ins.fw;
            overflow_write = ins.ow;
            reg_wr_en      = ins.rw;
            FLAG_IN        = ins.flag;
            MEM_READ       = is_rd;
            MEM_WRITE      = is_wr;
            mem_ack        = 1'($urandom);
            Start          = ($urandom_range(0, 3) == 0);

            if (ins.kind == K_HALT) begin
                MEM_READ  = 1'($urandom);
                MEM_WRITE = 1'($urandom);
                stepCheck("exec_halt", packExp(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1);
                model_done = 1'b1;
                break;
            end else if (is_rd || is_wr) begin
                stepCheck("exec_mem", packExp(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1);
                for (int k = 0; k < MEM_TIMEOUT; k++) begin
                    mem_ack = (k == ins.ack_at);
                    Start   = ($urandom_range(0, 3) == 0);
                    if (mem_ack) begin
                        stepCheck("mem_ack", packExp(0, 0, 1, 0, is_rd, 0, 0, 1, is_wr, 1), 1'b1);
                        break;
                    end
                    stepCheck("mem_wait", packExp(0, 0, 0, 0, 0, 0, 0, 1, is_wr, 1), 1'b1);
                    if (k == MEM_TIMEOUT - 1) timed_out = 1'b1;
                end
                if (timed_out) begin
                    model_done    = 1'b1;
                    model_bus_err = 1'b1;
                    break;
                end
            end else begin
                taken = ins.br & ins.flag;
                stepCheck("exec", packExp(0, 0, !taken, taken, ins.rw, ins.fw, ins.ow, 0, 0, 1), 1'b1);
            end
        end

        // Sitting in HALT: status holds and the count stays frozen.
        randomizeJunk();
        Start = 1'b0;
        stepCheck("halt", packExp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        checkOutput("cycle_count", 32'(cycle_count), 32'(model_cycles));
        prog_id++;
    endtask

    initial begin
        logic [11:0] zero_vec;
        int          n;
        int          r;
        int          kind;
        int          ack_at;

        prog_id       = 0;
        model_done    = 1'b0;
        model_bus_err = 1'b0;
        model_cycles  = 0;
        zero_vec      = 12'h000;
        Reset         = 1'b1;
        Start         = 1'b0;
        randomizeJunk();
        mem_ack       = 1'b0;

        #1;
        checkOutput("reset_strobes", {20'b0, observedStrobes()}, {20'b0, zero_vec});
        checkOutput("reset_count", 32'(cycle_count), 32'd0);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        stepCheck("idle", packExp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);

        // ADD, ADD, HALT
        program_q = {};
        program_q.push_back(mkInstr(K_ALU, 0, 0, 0, 1, 0, 0));
        program_q.push_back(mkInstr(K_ALU, 0, 0, 0, 1, 0, 0));
        program_q.push_back(mkInstr(K_HALT, 0, 0, 0, 0, 0, 0));
        applyStimulus();

        // Same branch taken then not taken
        program_q = {};
        program_q.push_back(mkInstr(K_ALU, 1, 0, 0, 0, 1, 0));
        program_q.push_back(mkInstr(K_ALU, 1, 0, 0, 0, 0, 0));
        program_q.push_back(mkInstr(K_HALT, 0, 0, 0, 0, 0, 0));
        applyStimulus();

        // Load answered after three wait cycles
        program_q = {};
        program_q.push_back(mkInstr(K_LW, 0, 0, 0, 1, 0, 3));
        program_q.push_back(mkInstr(K_HALT, 0, 0, 0, 0, 0, 0));
        applyStimulus();

        // Store that never completes
        program_q = {};
        program_q.push_back(mkInstr(K_SW, 0, 0, 0, 1, 0, -1));
        program_q.push_back(mkInstr(K_ALU, 0, 1, 1, 1, 0, 0));
        applyStimulus();

        // Load answered in the last allowed cycle
        program_q = {};
        program_q.push_back(mkInstr(K_LW, 0, 0, 0, 1, 0, MEM_TIMEOUT - 1));
        program_q.push_back(mkInstr(K_HALT, 0, 0, 0, 0, 0, 0));
        applyStimulus();

        // Asynchronous reset while waiting in MEM
        randomizeJunk();
        Start = 1'b1;
        stepCheck("rst_start", packExp(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        model_done    = 1'b0;
        model_bus_err = 1'b0;
        Start         = 1'b0;
        randomizeJunk();
        stepCheck("rst_fetch", packExp(0, 1, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1);
        Instruction = 9'h012;
        MEM_READ    = 1'b1;
        MEM_WRITE   = 1'b0;
        mem_ack     = 1'b0;
        stepCheck("rst_exec", packExp(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1);
        stepCheck("rst_mem0", packExp(0, 0, 0, 0, 0, 0, 0, 1, 0, 1), 1'b1);
        #2;
        Reset = 1'b1;
        #1;
        model_cycles = 0;
        checkOutput("rst_mid_mem_strobes", {20'b0, observedStrobes()}, {20'b0, zero_vec});
        checkOutput("rst_mid_mem_count", 32'(cycle_count), 32'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        prog_id++;

        // Random programs
        for (int p = 0; p < 30; p++) begin
            program_q = {};
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                kind = $urandom_range(K_ALU, K_SW);
                r    = $urandom_range(0, 9);
                if (r == 0)      ack_at = -1;
                else if (r == 1) ack_at = MEM_TIMEOUT - 1;
                else             ack_at = $urandom_range(0, 4);
                program_q.push_back(mkInstr(kind, 1'($urandom), 1'($urandom), 1'($urandom),
                                            1'($urandom), 1'($urandom), ack_at));
            end
            program_q.push_back(mkInstr(K_HALT, 0, 0, 0, 0, 0, 0));
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks_done, checks_failed);
        $finish;
    end

endmodule
